act_led_ctrl: RTL

ACT_LED_CTRL -- requirements
Module: act_led_ctrl

---
 rtl/act_led_pkg.sv | 22 ++
 rtl/act_blink.sv | 111 +++++++++++
 rtl/act_led_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/act_led_pkg.sv
// ==== act_led_pkg : shared types/constants for activity LED control (rev 1.0) ====
`default_nettype none

package act_led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } blink_state_t;

    localparam int MASK_LEN = 3;
    localparam int HB_TICKS = 500;
    localparam int HB_W     = 9;

    function automatic int ms_div(input int clk_hz);
        return clk_hz / 1000;
    endfunction

endpackage

`default_nettype wire

// File: rtl/act_blink.sv
// ==== act_blink : per-channel sync, edge detect and blink FSM (rev 1.0) ====
`default_nettype none

module act_blink
    import act_led_pkg::*;
#(
    parameter int ON_MS  = 50,
    parameter int OFF_MS = 50
) (
    input  logic clk,
    input  logic reset_n,
    input  logic act_in,
    input  logic ms_tick,
    input  logic ev_en,
    output logic led_out,
    output logic busy
);

    localparam int TMAX = (ON_MS > OFF_MS) ? ON_MS : OFF_MS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_MS);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_MS);
    localparam logic [TW-1:0] ONE      = TW'(1);

    logic sync1, sync2, hist;
    logic act_evt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= act_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // Any change counts as activity; ev_en suppresses the reset-release transient.
    assign act_evt = ev_en & (sync2 ^ hist);

    blink_state_t    state, state_nx;
    logic [TW-1:0]   timer, timer_nx;
    logic            pending, pending_nx;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            timer   <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_nx;
            timer   <= timer_nx;
            pending <= pending_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        timer_nx   = timer;
        pending_nx = pending;
        case (state)
            ST_IDLE: begin
                if (act_evt) begin
                    state_nx   = ST_ON;
                    timer_nx   = ON_LOAD;
                    pending_nx = 1'b0;
                end
            end
            ST_ON: begin
                if (act_evt) pending_nx = 1'b1;
                if (ms_tick) begin
                    if (timer == ONE) begin
                        state_nx = ST_OFF;
                        timer_nx = OFF_LOAD;
                    end else begin
                        timer_nx = timer - ONE;
                    end
                end
            end
            ST_OFF: begin
                if (ms_tick && timer == ONE) begin
                    // An event landing on the exit cycle still earns a blink.
                    if (pending || act_evt) begin
                        state_nx = ST_ON;
                        timer_nx = ON_LOAD;
                    end else begin
                        state_nx = ST_IDLE;
                        timer_nx = '0;
                    end
                    pending_nx = 1'b0;
                end else begin
                    if (act_evt) pending_nx = 1'b1;
                    if (ms_tick) timer_nx = timer - ONE;
                end
            end
            default: begin
                state_nx   = ST_IDLE;
                timer_nx   = '0;
                pending_nx = 1'b0;
            end
        endcase
    end

    assign led_out = (state == ST_ON);
    assign busy    = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: rtl/act_led_ctrl.sv
// ==== act_led_ctrl : multi-channel activity LED stretcher with ms prescaler (rev 1.0) ====
// ==== Optional heartbeat LED enabled by defining ACT_LED_HEARTBEAT_EN ====
`default_nettype none

module act_led_ctrl
    import act_led_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int NCH    = 4,
    parameter int ON_MS  = 50,
    parameter int OFF_MS = 50
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [NCH-1:0] act_in,
    output logic [NCH-1:0] led_out,
    output logic           busy,
    output logic           hb_out
);

    localparam int MS_DIV = ms_div(CLK_HZ);
    localparam int PW     = $clog2(MS_DIV + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(MS_DIV - 1);
    localparam int MW     = $clog2(MASK_LEN + 1);
    localparam logic [MW-1:0] MASK_DONE = MW'(MASK_LEN);

    logic [PW-1:0]  pre_cnt;
    logic           ms_tick;
    logic [MW-1:0]  mask_cnt;
    logic           ev_en;
    logic [NCH-1:0] ch_busy;

    always_ff @(posedge clk) begin
        if (!reset_n)     pre_cnt <= '0;
        else if (ms_tick) pre_cnt <= '0;
        else              pre_cnt <= pre_cnt + PW'(1);
    end

    assign ms_tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n)                 mask_cnt <= '0;
        else if (mask_cnt != MASK_DONE) mask_cnt <= mask_cnt + MW'(1);
    end

    assign ev_en = (mask_cnt == MASK_DONE);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        act_blink #(
            .ON_MS  (ON_MS),
            .OFF_MS (OFF_MS)
        ) u_blink (
            .clk     (clk),
            .reset_n (reset_n),
            .act_in  (act_in[i]),
            .ms_tick (ms_tick),
            .ev_en   (ev_en),
            .led_out (led_out[i]),
            .busy    (ch_busy[i])
        );
    end

    assign busy = |ch_busy;

`ifdef ACT_LED_HEARTBEAT_EN
    logic [HB_W-1:0] hb_cnt;
    logic            hb_q;

    // Toggle every HB_TICKS ms gives a 1 Hz blink.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hb_cnt <= '0;
            hb_q   <= 1'b0;
        end else if (ms_tick) begin
            if (hb_cnt == HB_W'(HB_TICKS - 1)) begin
                hb_cnt <= '0;
                hb_q   <= ~hb_q;
            end else begin
                hb_cnt <= hb_cnt + HB_W'(1);
            end
        end
    end

    assign hb_out = hb_q;
`else
    assign hb_out = 1'b0;
`endif

endmodule

`default_nettype wire
